// File: rtl/emblem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : emblem_seq_ctrl
// Description : Frame-synchronous reveal sequencer for an emblem overlay.
//               A start command runs WIPE (emblem rows revealed top-down,
//               WIPE_STEP rows per frame), HOLD (full emblem for HOLD_FRAMES
//               frames) and optionally BLINK (BLINK_COUNT off/on cycles of
//               BLINK_PERIOD frames per half), then returns to IDLE with a
//               one-cycle done pulse. Each pixel is composited against the
//               background and registered.
//
// Build option: define EMBLEM_SEQ_BLINK_EN to include the BLINK phase.
//               Without it, the last HOLD frame returns straight to IDLE and
//               phase never reads 3.
//
// Ports:
//   clk          pixel clock, all state on rising edge
//   rst          asynchronous active-high reset
//   x, y [9:0]   current pixel coordinate
//   active       visible-area flag
//   frame_tick   one-cycle pulse per frame (vertical blanking)
//   start, stop  one-cycle sequence commands (stop has priority)
//   emb_draw     emblem generator draw flag
//   emb_rgb[5:0] emblem colour
//   bg_rgb[5:0]  background colour
//   rgb_out[5:0] registered composited pixel (1 cycle latency)
//   busy         high whenever phase is not IDLE
//   done         one-cycle pulse on normal sequence completion
//   phase[1:0]   IDLE=0, WIPE=1, HOLD=2, BLINK=3
//
// Revision    : 1.0 - initial release
// ============================================================================
module emblem_seq_ctrl #(
    parameter int WIPE_STEP    = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_PERIOD = 8,
    parameter int BLINK_COUNT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       stop,
    input  logic       emb_draw,
    input  logic [5:0] emb_rgb,
    input  logic [5:0] bg_rgb,
    output logic [5:0] rgb_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WIPE  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_BLINK = 2'd3
    } state_t;

    // Emblem occupies rows 144..319, i.e. 176 rows.
    localparam logic [9:0] c_emb_top     = 10'd144;
    localparam logic [9:0] c_emb_bot     = 10'd320;
    localparam logic [8:0] c_reveal_max  = 9'd176;
    localparam logic [8:0] c_wipe_step   = 9'(WIPE_STEP);
    localparam logic [7:0] c_hold_last   = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] c_blink_last  = 8'(2 * BLINK_PERIOD * BLINK_COUNT - 1);
    localparam logic [7:0] c_blink_per   = 8'(BLINK_PERIOD);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_reveal;
    logic [7:0] w_reveal_nxt;
    logic [7:0] r_frame_cnt;
    logic [7:0] w_frame_cnt_nxt;
    logic       r_done;
    logic       w_done_nxt;
    logic [8:0] w_reveal_sum;
    logic [9:0] w_y_rel;
    logic       w_in_band;
    logic       w_blink_on;
    logic       w_show;
    logic       w_unused_x;

    // The column is irrelevant: the wipe is purely row-based.
    assign w_unused_x = ^x;

    assign w_reveal_sum = {1'b0, r_reveal} + c_wipe_step;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_reveal    <= 8'd0;
            r_frame_cnt <= 8'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_reveal    <= w_reveal_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Counters only move on frame_tick, start or stop,
    // so the revealed region is constant within a frame.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_reveal_nxt    = r_reveal;
        w_frame_cnt_nxt = r_frame_cnt;
        w_done_nxt      = 1'b0;

        if (stop) begin
            w_state_nxt     = ST_IDLE;
            w_reveal_nxt    = 8'd0;
            w_frame_cnt_nxt = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A tick in the same cycle as start does not advance the wipe.
                    if (start) begin
                        w_state_nxt     = ST_WIPE;
                        w_reveal_nxt    = 8'd0;
                        w_frame_cnt_nxt = 8'd0;
                    end
                end
                ST_WIPE: begin
                    if (frame_tick) begin
                        if (w_reveal_sum >= c_reveal_max) begin
                            w_reveal_nxt    = c_reveal_max[7:0];
                            w_state_nxt     = ST_HOLD;
                            w_frame_cnt_nxt = 8'd0;
                        end else begin
                            w_reveal_nxt    = w_reveal_sum[7:0];
                        end
                    end
                end
                ST_HOLD: begin
                    if (frame_tick) begin
                        if (r_frame_cnt == c_hold_last) begin
                            w_frame_cnt_nxt = 8'd0;
`ifdef EMBLEM_SEQ_BLINK_EN
                            w_state_nxt     = ST_BLINK;
`else
                            w_state_nxt     = ST_IDLE;
                            w_done_nxt      = 1'b1;
`endif
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                        end
                    end
                end
                ST_BLINK: begin
                    // Only reachable when the blink phase is built in.
                    if (frame_tick) begin
                        if (r_frame_cnt == c_blink_last) begin
                            w_state_nxt     = ST_IDLE;
                            w_frame_cnt_nxt = 8'd0;
                            w_done_nxt      = 1'b1;
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Visibility of the emblem for the current pixel
    // ------------------------------------------------------------------
    assign w_y_rel    = y - c_emb_top;
    assign w_in_band  = (y >= c_emb_top) && (y < c_emb_bot);
    // Blink starts in the hidden half-cycle.
    assign w_blink_on = ((r_frame_cnt / c_blink_per) % 8'd2) == 8'd1;

    always_comb begin
        w_show = 1'b0;
        case (r_state)
            ST_IDLE:  w_show = 1'b0;
            ST_WIPE:  w_show = w_in_band && (w_y_rel < {2'b00, r_reveal});
            ST_HOLD:  w_show = 1'b1;
            ST_BLINK: w_show = w_blink_on;
            default:  w_show = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered compositor
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out <= 6'd0;
        end else if (!active) begin
            rgb_out <= 6'd0;
        end else if (w_show && emb_draw) begin
            rgb_out <= emb_rgb;
        end else begin
            rgb_out <= bg_rgb;
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = r_done;
    assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_emblem_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_emblem_seq_ctrl
// Description : Self-checking bench for emblem_seq_ctrl. Expected pixels are
//               pushed to a scoreboard queue when driven and popped when the
//               registered output appears. Sequence expectations are derived
//               from the frame-tick count since start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emblem_seq_ctrl;

`ifdef EMBLEM_SEQ_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif
    localparam int T_HOLD  = 44;
    localparam int T_BLINK = 164;
    localparam int T_END   = BLINK_EN ? 212 : 164;

    localparam logic [5:0] C_EMB = 6'h2A;
    localparam logic [5:0] C_BG  = 6'h15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       active = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       emb_draw = 1'b0;
    logic [5:0] emb_rgb = C_EMB;
    logic [5:0] bg_rgb = C_BG;
    logic [5:0] rgb_out;
    logic       busy;
    logic       done;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;
    logic [5:0] sb_q[$];

    emblem_seq_ctrl #(
        .WIPE_STEP   (4),
        .HOLD_FRAMES (120),
        .BLINK_PERIOD(8),
        .BLINK_COUNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .active    (active),
        .frame_tick(frame_tick),
        .start     (start),
        .stop      (stop),
        .emb_draw  (emb_draw),
        .emb_rgb   (emb_rgb),
        .bg_rgb    (bg_rgb),
        .rgb_out   (rgb_out),
        .busy      (busy),
        .done      (done),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected phase after i ticks since start (i >= 0).
    function automatic int exp_phase(input int i);
        if (i < T_HOLD)                  return 1;
        if (i < T_BLINK)                 return 2;
        if (BLINK_EN && i < 212)         return 3;
        return 0;
    endfunction

    function automatic bit exp_show(input int i, input int yy);
        int ph;
        int rev;
        ph  = exp_phase(i);
        rev = (4 * i > 176) ? 176 : 4 * i;
        case (ph)
            1:       return (yy >= 144) && (yy < 320) && ((yy - 144) < rev);
            2:       return 1'b1;
            3:       return (((i - T_BLINK) / 8) % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] exp_rgb(input bit act, input bit draw, input bit shw);
        if (!act)         return 6'd0;
        if (shw && draw)  return C_EMB;
        return C_BG;
    endfunction

    task automatic tick(input bit s_start, input bit s_stop);
        frame_tick = 1'b1;
        start      = s_start;
        stop       = s_stop;
        cyc();
        frame_tick = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Drive one pixel, queue its expected colour, compare on output.
    task automatic pix(input string name, input int yy, input bit act, input bit draw,
                       input logic [5:0] expv);
        logic [5:0] want;
        sb_q.push_back(expv);
        y        = 10'(yy);
        x        = 10'(yy + 3);
        active   = act;
        emb_draw = draw;
        cyc();
        want = sb_q.pop_front();
        checks++;
        if (rgb_out !== want) begin
            errors++;
            $display("FAIL %s: rgb_out=%h expected=%h", name, rgb_out, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (rgb_out !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || phase !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: rgb=%h busy=%b done=%b phase=%0d expected 0/0/0/0",
                     rgb_out, busy, done, phase);
        end
        rst = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        pix("idle_active", 200, 1'b1, 1'b1, C_BG);
        pix("idle_blank", 200, 1'b0, 1'b1, 6'd0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b expected=0", busy);
        end
    endtask

    task automatic test_wipe();
        // start coinciding with frame_tick must not advance the wipe
        tick(1'b1, 1'b0);
        checks++;
        if (phase !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wipe_enter: phase=%0d busy=%b expected 1/1", phase, busy);
        end
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b0);
        pix("wipe_y183", 183, 1'b1, 1'b1, C_EMB);
        pix("wipe_y184", 184, 1'b1, 1'b1, C_BG);
        pix("wipe_y143", 143, 1'b1, 1'b1, C_BG);
        pix("wipe_nodraw", 150, 1'b1, 1'b0, C_BG);
        tick(1'b0, 1'b1);
        checks++;
        if (phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL wipe_stop: phase=%0d busy=%b done=%b expected 0/0/0", phase, busy, done);
        end
    endtask

    task automatic test_full_run();
        int ph;
        do_start();
        checks++;
        if (phase !== 2'd1) begin
            errors++;
            $display("FAIL run_start: phase=%0d expected=1", phase);
        end
        for (int i = 1; i <= T_END; i++) begin
            tick(1'b0, 1'b0);
            ph = exp_phase(i);
            checks++;
            if (phase !== 2'(ph) || done !== (i == T_END)) begin
                errors++;
                $display("FAIL run_tick%0d: phase=%0d done=%b expected %0d/%b",
                         i, phase, done, ph, (i == T_END));
            end
            if (phase === 2'd3 && !BLINK_EN) begin
                checks++;
                errors++;
                $display("FAIL run_phase3: phase=3 without blink build");
            end
            if (i == T_END) begin
                cyc();
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL run_done_width: done=%b busy=%b expected 0/0", done, busy);
                end
            end else if (i == 5 || i == 44 || i == 100 || i == 164 || i == 171 ||
                         i == 172 || i == 180) begin
                pix("run_y160", 160, 1'b1, 1'b1, exp_rgb(1'b1, 1'b1, exp_show(i, 160)));
                pix("run_y200", 200, 1'b1, 1'b1, exp_rgb(1'b1, 1'b1, exp_show(i, 200)));
            end
        end
    endtask

    task automatic test_stop();
        do_start();
        for (int i = 1; i < 50; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if (phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: phase=%0d busy=%b done=%b expected 0/0/0", phase, busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (done !== 1'b0 || phase !== 2'd0) begin
                errors++;
                $display("FAIL stop_quiet: done=%b phase=%0d expected 0/0", done, phase);
            end
        end
        do_start();
        tick(1'b0, 1'b0);
        checks++;
        if (phase !== 2'd1) begin
            errors++;
            $display("FAIL restart_phase: phase=%0d expected=1", phase);
        end
        pix("restart_y144", 144, 1'b1, 1'b1, C_EMB);
        pix("restart_y148", 148, 1'b1, 1'b1, C_BG);
        tick(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_start();
        for (int i = 1; i <= 60; i++) tick(1'b0, 1'b0);
        pix("hold_before_rst", 200, 1'b1, 1'b1, C_EMB);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rgb_out !== 6'd0 || busy !== 1'b0 || done !== 1'b0 || phase !== 2'd0) begin
            errors++;
            $display("FAIL async_rst: rgb=%h busy=%b done=%b phase=%0d expected 0/0/0/0",
                     rgb_out, busy, done, phase);
        end
        #2;
        rst = 1'b0;
        active = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL rst_wait: busy=%b done=%b expected 0/0", busy, done);
            end
        end
        test_full_run();
    endtask

    initial begin
        test_reset();
        test_wipe();
        test_full_run();
        test_stop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/emblem_seq_ctrl.md
EMBLEM_SEQ_CTRL -- requirements
Module: emblem_seq_ctrl

Interface
REQ-001 Parameter WIPE_STEP, default 4: emblem rows revealed per frame during the wipe.
REQ-002 Parameter HOLD_FRAMES, default 120: frames the full emblem is held.
REQ-003 Parameter BLINK_PERIOD, default 8: frames per blink half-cycle.
REQ-004 Parameter BLINK_COUNT, default 3: number of off/on blink cycles.
REQ-005 Port clk, input, 1: pixel clock; one clock; all state on rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port x, y, input, 10 each: current pixel coordinate, same timing as the emblem generator inputs.
REQ-008 Port active, input, 1: visible-area flag.
REQ-009 Port frame_tick, input, 1: one-cycle pulse per frame, issued during vertical blanking.
REQ-010 Port start, stop, input, 1 each: one-cycle sequence commands.
REQ-011 Port emb_draw, input, 1 and emb_rgb, input, 6: emblem generator draw flag and colour.
REQ-012 Port bg_rgb, input, 6: background colour.
REQ-013 Port rgb_out, output, 6: registered composited pixel.
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Port done, output, 1: one-cycle completion pulse.
REQ-016 Port phase, output, 2: encoded state: IDLE=0, WIPE=1, HOLD=2, BLINK=3.

Function
REQ-017 The FSM SHALL use states IDLE, WIPE, HOLD and BLINK, held in a registered phase.
REQ-018 start in IDLE SHALL enter WIPE on the next edge with reveal_line=0 (8 bit) and frame_cnt=0 (8 bit); start outside IDLE SHALL be ignored.
REQ-019 stop SHALL force IDLE on the next edge from any state, with no done pulse; stop SHALL win over a simultaneous start.
REQ-020 In WIPE, each frame_tick SHALL add WIPE_STEP to reveal_line, saturating at 176 (emblem rows 144..319).
REQ-021 The tick that makes reveal_line reach 176 SHALL enter HOLD with frame_cnt=0.
REQ-022 In HOLD, each frame_tick SHALL increment frame_cnt; the tick on which frame_cnt==HOLD_FRAMES-1 SHALL enter BLINK with frame_cnt=0.
REQ-023 In BLINK, each frame_tick SHALL increment frame_cnt; the emblem SHALL be hidden when (frame_cnt/BLINK_PERIOD) is even and shown when odd.
REQ-024 The tick on which frame_cnt==2*BLINK_PERIOD*BLINK_COUNT-1 SHALL enter IDLE and assert done for exactly one cycle.
REQ-025 A frame_tick coinciding with start SHALL NOT advance reveal_line.
REQ-026 show SHALL be 0 in IDLE, (y-144)<reveal_line with 144<=y<320 in WIPE, 1 in HOLD, and the blink phase in BLINK.
REQ-027 rgb_out SHALL register, with one-cycle latency: 0 when active=0; emb_rgb when show and emb_draw are both high; bg_rgb otherwise.
REQ-028 All counters SHALL change only on frame_tick, start, stop or reset, so a frame never tears.

Reset
REQ-029 rst SHALL asynchronously set phase=IDLE, reveal_line=0, frame_cnt=0, rgb_out=0, busy=0 and done=0.
REQ-030 Reset asserted mid-sequence SHALL abort without a done pulse; after release the block SHALL wait for a new start.

Configuration
REQ-031 With macro EMBLEM_SEQ_BLINK_EN defined, BLINK SHALL behave per REQ-023/024.
REQ-032 Without EMBLEM_SEQ_BLINK_EN, the final HOLD tick SHALL enter IDLE directly with done, BLINK SHALL be unreachable, and phase SHALL never read 3.

Verification
REQ-033 Reset release, no start, 3 frames -> rgb_out==bg_rgb in the active area, 0 elsewhere; busy=0.
REQ-034 start, then 10 ticks (defaults) -> reveal_line=40; pixel y=183 with emb_draw shows emb_rgb; y=184 shows bg_rgb.
REQ-035 Full run with EMBLEM_SEQ_BLINK_EN, defaults -> HOLD after 44 ticks, BLINK after 164, done pulse after 212; frames 165-172 show bg_rgb.
REQ-036 stop at tick 50, with start in the same cycle -> IDLE next edge, done never asserted; a later start restarts WIPE at reveal_line=0.
REQ-037 rst pulsed mid-HOLD -> all outputs 0 immediately; start after release -> full sequence repeats.
REQ-038 Build without EMBLEM_SEQ_BLINK_EN -> done after 164 ticks; phase never 3.
